// File: rtl/x9_fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   fetch_state_t      : sequencer state (IDLE / RUN / DONE)
//   X9_D               : default fetch address width (ROM depth 2**X9_D)
//   X9_OFS_W           : default relative branch offset width
//   X9_CT_W            : default executed-cycle counter width
//   X9_START_ADDR      : default program entry address
package x9_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int          X9_D          = 12;
  localparam int          X9_OFS_W      = 8;
  localparam int          X9_CT_W       = 16;
  localparam int unsigned X9_START_ADDR = 0;

endpackage

// File: rtl/next_pc_logic.sv
// Next fetch address selection for the sequencer while running.
//   pc             in   D      current fetch address
//   halt           in   1      hold PC (halt instruction stays addressed)
//   stall          in   1      hold PC; a simultaneous branch is dropped
//   branch_en      in   1      redirect fetch
//   branch_abs     in   1      1: absolute target, 0: PC-relative
//   branch_target  in   D      absolute target
//   branch_offset  in   OFS_W  signed relative offset
//   next_pc        out  D      address to load on the next edge
module next_pc_logic
  import x9_fetch_pkg::*;
#(
  parameter int D     = X9_D,
  parameter int OFS_W = X9_OFS_W
) (
  input  logic                    [D-1:0] pc,
  input  logic                            halt,
  input  logic                            stall,
  input  logic                            branch_en,
  input  logic                            branch_abs,
  input  logic                    [D-1:0] branch_target,
  input  logic signed         [OFS_W-1:0] branch_offset,
  output logic                    [D-1:0] next_pc
);

  logic signed [D-1:0] ofs_ext;

  // Size cast of a signed operand sign-extends to D bits; the D-bit add
  // below then discards the carry, giving modulo-2**D arithmetic.
  assign ofs_ext = D'(branch_offset);

  always_comb begin
    next_pc = pc + D'(1);
    if (halt || stall) begin
      next_pc = pc;
    end else if (branch_en) begin
      if (branch_abs) next_pc = branch_target;
      else            next_pc = pc + $unsigned(ofs_ext);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the combinational instruction ROM.
//   clk            in   1      system clock, rising edge
//   reset          in   1      synchronous active-high reset
//   start          in   1      begin/restart program (IDLE/DONE only)
//   stall          in   1      hold PC this cycle (RUN only)
//   halt           in   1      current instruction is halt; stop after it
//   branch_en      in   1      redirect fetch this cycle
//   branch_abs     in   1      1: absolute target, 0: PC-relative offset
//   branch_target  in   D      absolute target
//   branch_offset  in   OFS_W  signed relative offset
//   prog_ctr       out  D      registered ROM fetch address
//   running        out  1      high while in RUN
//   done           out  1      high while in DONE
//   cycle_ct       out  CT_W   RUN cycles since last start (saturating)
module fetch_sequencer
  import x9_fetch_pkg::*;
#(
  parameter int          D          = X9_D,
  parameter int unsigned START_ADDR = X9_START_ADDR,
  parameter int          OFS_W      = X9_OFS_W,
  parameter int          CT_W       = X9_CT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    halt,
  input  logic                    branch_en,
  input  logic                    branch_abs,
  input  logic            [D-1:0] branch_target,
  input  logic signed [OFS_W-1:0] branch_offset,
  output logic            [D-1:0] prog_ctr,
  output logic                    running,
  output logic                    done,
  output logic         [CT_W-1:0] cycle_ct
);

  localparam logic [D-1:0] START_PC = D'(START_ADDR);

  if (D < OFS_W) begin : g_bad_widths
    $error("fetch_sequencer: D must be >= OFS_W");
  end

  function automatic logic [CT_W-1:0] sat_inc(input logic [CT_W-1:0] v);
    return (&v) ? v : v + CT_W'(1);
  endfunction

  fetch_state_t   state_q;
  logic [D-1:0]   next_pc;

  next_pc_logic #(
    .D     (D),
    .OFS_W (OFS_W)
  ) u_next_pc (
    .pc            (prog_ctr),
    .halt          (halt),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_abs    (branch_abs),
    .branch_target (branch_target),
    .branch_offset (branch_offset),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prog_ctr <= START_PC;
      cycle_ct <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          // PC and counter stay frozen until a (re)start.
          if (start) begin
            state_q  <= RUN;
            prog_ctr <= START_PC;
            cycle_ct <= '0;
          end
        end
        RUN: begin
          // The halt cycle itself is counted.
          cycle_ct <= sat_inc(cycle_ct);
          prog_ctr <= next_pc;
          if (halt) state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int D     = 12;
  localparam int OFS_W = 8;
  localparam int CT_W  = 6;
  localparam int PC_MOD = 1 << D;
  localparam int CT_MAX = (1 << CT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic             halt = 1'b0;
  logic             branch_en = 1'b0;
  logic             branch_abs = 1'b0;
  logic [D-1:0]     branch_target = '0;
  logic [OFS_W-1:0] branch_offset = '0;
  logic [D-1:0]     prog_ctr;
  logic             running;
  logic             done;
  logic [CT_W-1:0]  cycle_ct;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .D          (D),
    .START_ADDR (0),
    .OFS_W      (OFS_W),
    .CT_W       (CT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .halt          (halt),
    .branch_en     (branch_en),
    .branch_abs    (branch_abs),
    .branch_target (branch_target),
    .branch_offset (branch_offset),
    .prog_ctr      (prog_ctr),
    .running       (running),
    .done          (done),
    .cycle_ct      (cycle_ct)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = finished.
  bit m_valid = 1'b0;
  int m_mode  = 0;
  int m_pc    = 0;
  int m_ct    = 0;

  always @(posedge clk) begin
    int ofs;
    if (reset) begin
      m_valid = 1'b1;
      m_mode  = 0;
      m_pc    = 0;
      m_ct    = 0;
    end else if (m_valid) begin
      if (m_mode != 1) begin
        if (start) begin
          m_mode = 1;
          m_pc   = 0;
          m_ct   = 0;
        end
      end else begin
        m_ct = (m_ct < CT_MAX) ? m_ct + 1 : CT_MAX;
        if (halt) begin
          m_mode = 2;
        end else if (stall) begin
          m_pc = m_pc;
        end else if (branch_en && branch_abs) begin
          m_pc = int'(branch_target);
        end else if (branch_en) begin
          ofs = int'(branch_offset);
          if (ofs >= (1 << (OFS_W - 1))) ofs = ofs - (1 << OFS_W);
          m_pc = ((m_pc + ofs) % PC_MOD + PC_MOD) % PC_MOD;
        end else begin
          m_pc = (m_pc + 1) % PC_MOD;
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle check of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      cmp("pc",      int'(prog_ctr), m_pc);
      cmp("running", int'(running),  (m_mode == 1) ? 1 : 0);
      cmp("done",    int'(done),     (m_mode == 2) ? 1 : 0);
      cmp("cycle_ct", int'(cycle_ct), m_ct);
    end
  end

  // Hand-computed expectation: pins both the DUT and the model.
  task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
    cmp({name, "_dut"}, dut_v, exp);
    cmp({name, "_model"}, mdl_v, exp);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; halt = 0; branch_en = 0; branch_abs = 0;
    branch_target = '0; branch_offset = '0;
  endtask

  task automatic br_abs(input int tgt);
    branch_en = 1; branch_abs = 1; branch_target = D'(tgt);
  endtask

  initial begin
    // Reset state
    reset = 1; cyc(2);
    lit("rst_pc", int'(prog_ctr), m_pc, 0);
    lit("rst_running", int'(running), (m_mode == 1) ? 1 : 0, 0);
    lit("rst_done", int'(done), (m_mode == 2) ? 1 : 0, 0);
    lit("rst_ct", int'(cycle_ct), m_ct, 0);

    // Start and free-run
    reset = 0; start = 1; cyc(); start = 0;
    lit("start_pc", int'(prog_ctr), m_pc, 0);
    lit("start_running", int'(running), (m_mode == 1) ? 1 : 0, 1);
    cyc(5);
    lit("run5_pc", int'(prog_ctr), m_pc, 5);
    lit("run5_ct", int'(cycle_ct), m_ct, 5);

    // Branches
    br_abs(10); cyc();
    lit("abs10", int'(prog_ctr), m_pc, 10);
    branch_abs = 0; branch_offset = 8'hFD; cyc();
    lit("rel_m3", int'(prog_ctr), m_pc, 7);
    br_abs('h0A3); cyc();
    lit("abs_a3", int'(prog_ctr), m_pc, 'h0A3);

    // Wrap-around
    br_abs('hFFF); cyc(); clear_inputs(); cyc();
    lit("wrap_inc", int'(prog_ctr), m_pc, 0);
    br_abs('hFFE); cyc(); branch_abs = 0; branch_offset = 8'd5; cyc();
    lit("wrap_rel", int'(prog_ctr), m_pc, 3);

    // Stall drops branch, then halt beats branch
    br_abs(20); cyc();
    branch_target = 12'h055; stall = 1; cyc(2);
    lit("stall_pc", int'(prog_ctr), m_pc, 20);
    clear_inputs(); cyc();
    lit("unstall_pc", int'(prog_ctr), m_pc, 21);
    halt = 1; br_abs('h055); cyc(); clear_inputs();
    lit("halt_pc", int'(prog_ctr), m_pc, 21);
    lit("halt_done", int'(done), (m_mode == 2) ? 1 : 0, 1);
    lit("halt_running", int'(running), (m_mode == 1) ? 1 : 0, 0);
    stall = 1; halt = 1; br_abs('h123); cyc(3); clear_inputs();
    lit("done_frozen", int'(prog_ctr), m_pc, 21);

    // Restart from DONE, counter saturation, start ignored in RUN
    start = 1; cyc(); start = 0;
    lit("restart_pc", int'(prog_ctr), m_pc, 0);
    lit("restart_ct", int'(cycle_ct), m_ct, 0);
    lit("restart_done", int'(done), (m_mode == 2) ? 1 : 0, 0);
    cyc(70);
    lit("sat_ct", int'(cycle_ct), m_ct, CT_MAX);
    lit("run70_pc", int'(prog_ctr), m_pc, 70);
    start = 1; cyc(); start = 0;
    lit("start_in_run", int'(prog_ctr), m_pc, 71);

    // Reset mid-run, then idle ignores control
    br_abs(37); cyc(); clear_inputs();
    reset = 1; cyc(); reset = 0;
    lit("abort_pc", int'(prog_ctr), m_pc, 0);
    lit("abort_running", int'(running), (m_mode == 1) ? 1 : 0, 0);
    lit("abort_ct", int'(cycle_ct), m_ct, 0);
    stall = 1; halt = 1; br_abs('h200); cyc(3); clear_inputs();
    lit("idle_hold", int'(prog_ctr), m_pc, 0);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      reset         = ($urandom_range(0, 299) == 0);
      start         = ($urandom_range(0, 5) == 0);
      halt          = ($urandom_range(0, 39) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      branch_en     = ($urandom_range(0, 3) == 0);
      branch_abs    = $urandom_range(0, 1) == 1;
      branch_target = D'($urandom);
      branch_offset = OFS_W'($urandom);
      cyc();
    end
    clear_inputs();
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
